// File: rtl/dflop_pkg.sv
// Shared definitions for the D flip-flop checkers: monitor state encoding,
// golden-model priority constants, default widths and the next-state helper.
package dflop_pkg;

    // Monitor states: UNINIT = model value unknown, ARMED = comparing,
    // HALT = stopped after the first failure (left only by reset).
    typedef enum logic [1:0] {
        UNINIT = 2'd0,
        ARMED  = 2'd1,
        HALT   = 2'd2
    } monState_t;

    // Value forced by each control; reset_n has priority over set_n over d.
    localparam logic Q_ON_RESET = 1'b0;
    localparam logic Q_ON_SET   = 1'b1;

    // Default counter widths.
    localparam int DEF_CNT_W = 8;
    localparam int DEF_CYC_W = 16;

    // Next flop value for one clock edge given the sampled stimulus.
    function automatic logic nextQ(input logic d, input logic set_n, input logic reset_n);
        if (!reset_n)
            return Q_ON_RESET;
        else if (!set_n)
            return Q_ON_SET;
        else
            return d;
    endfunction

    // Both active-low controls asserted together leaves the flop undefined.
    function automatic logic ctrlIllegal(input logic set_n, input logic reset_n);
        return (!set_n) && (!reset_n);
    endfunction

endpackage

// File: rtl/dflop_if.sv
// Stimulus/response bundle of a single D flip-flop. The master side drives
// the flop's inputs and presents its outputs; the slave side only observes.
interface dflop_if;
    logic obs_d;
    logic obs_set_n;
    logic obs_reset_n;
    logic obs_q;
    logic obs_qbar;

    modport master (
        output obs_d,
        output obs_set_n,
        output obs_reset_n,
        output obs_q,
        output obs_qbar
    );

    modport slave (
        input obs_d,
        input obs_set_n,
        input obs_reset_n,
        input obs_q,
        input obs_qbar
    );
endinterface

// File: rtl/dflop_model.sv
// Golden D flip-flop. q_exp is the value the flop captured at the last edge;
// exp is what its q output should show right now, including the immediate
// effect of the asynchronous controls when ASYNC_CTRL is set.
module dflop_model
    import dflop_pkg::*;
#(
    parameter int unsigned ASYNC_CTRL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic set_n,
    input  logic reset_n,
    output logic q_exp,
    output logic exp
);

    logic r_qExp;

    // Capture the value the real flop takes at this edge.
    always_ff @(posedge clk) begin
        if (reset)
            r_qExp <= Q_ON_RESET;
        else
            r_qExp <= nextQ(d, set_n, reset_n);
    end

    assign q_exp = r_qExp;

    // Asynchronous controls override the stored value as soon as they assert;
    // synchronous controls only show up after the next edge.
    generate
        if (ASYNC_CTRL != 0) begin : g_asyncExp
            always_comb begin
                exp = r_qExp;
                if (!reset_n)
                    exp = Q_ON_RESET;
                else if (!set_n)
                    exp = Q_ON_SET;
            end
        end else begin : g_syncExp
            assign exp = r_qExp;
        end
    endgenerate

endmodule

// File: rtl/dflop_monitor.sv
// Response checker for one D flip-flop: tracks a golden model, compares the
// observed q/qbar every enabled cycle, counts failures and stamps the first.
module dflop_monitor
    import dflop_pkg::*;
#(
    parameter int unsigned ASYNC_CTRL   = 1,
    parameter int          CNT_W        = DEF_CNT_W,
    parameter int          CYC_W        = DEF_CYC_W,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    dflop_if.slave           obs,
    output logic             err,
    output logic             compl_err,
    output logic             illegal_ctrl,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CYC_W-1:0] first_err_cycle,
    output logic             armed
);

    monState_t        r_state;
    logic             r_armed;
    logic             r_err;
    logic             r_complErr;
    logic             r_illegalCtrl;
    logic [CNT_W-1:0] r_errCount;
    logic             r_firstErrValid;
    logic [CYC_W-1:0] r_firstErrCycle;
    logic [CYC_W-1:0] r_cycleCnt;

    logic w_qExp;
    logic w_exp;
    logic w_expNow;
    logic w_illegal;
    logic w_dataMis;
    logic w_complMis;

    dflop_model #(
        .ASYNC_CTRL (ASYNC_CTRL)
    ) u_model (
        .clk     (clk),
        .reset   (reset),
        .d       (obs.obs_d),
        .set_n   (obs.obs_set_n),
        .reset_n (obs.obs_reset_n),
        .q_exp   (w_qExp),
        .exp     (w_exp)
    );

    // With synchronous controls the captured model value is the expectation.
    assign w_expNow   = (ASYNC_CTRL != 0) ? w_exp : w_qExp;
    assign w_illegal  = ctrlIllegal(obs.obs_set_n, obs.obs_reset_n);
    assign w_dataMis  = (obs.obs_q != w_expNow);
    assign w_complMis = (obs.obs_q == obs.obs_qbar);

    // Monitor FSM with all status outputs registered. Illegal controls always
    // drop the monitor back to UNINIT, even with en low, because the model
    // value is no longer trustworthy; otherwise en low freezes the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= UNINIT;
            r_armed         <= 1'b0;
            r_err           <= 1'b0;
            r_complErr      <= 1'b0;
            r_illegalCtrl   <= 1'b0;
            r_errCount      <= '0;
            r_firstErrValid <= 1'b0;
            r_firstErrCycle <= '0;
            r_cycleCnt      <= '0;
        end else begin
            r_err         <= 1'b0;
            r_complErr    <= 1'b0;
            r_illegalCtrl <= w_illegal;
            case (r_state)
                UNINIT: begin
                    r_cycleCnt <= r_cycleCnt + CYC_W'(1);
                    if (en && !w_illegal) begin
                        r_state <= ARMED;
                        r_armed <= 1'b1;
                    end
                end
                ARMED: begin
                    r_cycleCnt <= r_cycleCnt + CYC_W'(1);
                    if (w_illegal) begin
                        r_state <= UNINIT;
                        r_armed <= 1'b0;
                    end else if (en && (w_dataMis || w_complMis)) begin
                        r_err      <= 1'b1;
                        r_complErr <= w_complMis;
                        if (!(&r_errCount))
                            r_errCount <= r_errCount + CNT_W'(1);
                        if (!r_firstErrValid) begin
                            r_firstErrValid <= 1'b1;
                            r_firstErrCycle <= r_cycleCnt;
                        end
                        if (STOP_ON_FAIL != 0) begin
                            r_state <= HALT;
                            r_armed <= 1'b0;
                        end
                    end
                end
                HALT: begin
                end
                default: begin
                    r_state <= UNINIT;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign err             = r_err;
    assign compl_err       = r_complErr;
    assign illegal_ctrl    = r_illegalCtrl;
    assign err_count       = r_errCount;
    assign first_err_valid = r_firstErrValid;
    assign first_err_cycle = r_firstErrCycle;
    assign armed           = r_armed;

endmodule

// File: tb/tb_dflop_monitor.sv
// Directed bench for dflop_monitor. The bench plays the monitored flop by
// driving q/qbar by hand. Three instances: dutA (async controls, 2-bit
// error counter), dutS (synchronous controls, same stimulus as dutA) and
// dutH (stops at the first failure).
module tb_dflop_monitor;

    logic clk = 1'b0;
    logic rstA, rstH, enA, enH;

    dflop_if ifA ();
    dflop_if ifH ();

    logic        errA, complA, illA, fvA, armA;
    logic [1:0]  cntA;
    logic [15:0] fcA;
    logic        errS, complS, illS, fvS, armS;
    logic [7:0]  cntS;
    logic [15:0] fcS;
    logic        errH, complH, illH, fvH, armH;
    logic [7:0]  cntH;
    logic [15:0] fcH;

    int checkCount = 0;
    int failCount  = 0;
    int complPulses;

    dflop_monitor #(.ASYNC_CTRL(1), .CNT_W(2), .CYC_W(16), .STOP_ON_FAIL(0)) dutA (
        .clk(clk), .reset(rstA), .en(enA), .obs(ifA),
        .err(errA), .compl_err(complA), .illegal_ctrl(illA), .err_count(cntA),
        .first_err_valid(fvA), .first_err_cycle(fcA), .armed(armA)
    );

    dflop_monitor #(.ASYNC_CTRL(0), .CNT_W(8), .CYC_W(16), .STOP_ON_FAIL(0)) dutS (
        .clk(clk), .reset(rstA), .en(enA), .obs(ifA),
        .err(errS), .compl_err(complS), .illegal_ctrl(illS), .err_count(cntS),
        .first_err_valid(fvS), .first_err_cycle(fcS), .armed(armS)
    );

    dflop_monitor #(.ASYNC_CTRL(1), .CNT_W(8), .CYC_W(16), .STOP_ON_FAIL(1)) dutH (
        .clk(clk), .reset(rstH), .en(enH), .obs(ifH),
        .err(errH), .compl_err(complH), .illegal_ctrl(illH), .err_count(cntH),
        .first_err_valid(fvH), .first_err_cycle(fcH), .armed(armH)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of flop stimulus/response, clock it, settle past the edge.
    task automatic applyStimulus(input bit toH, input logic e, input logic d, input logic sn,
                                 input logic rn, input logic q, input logic qb);
        if (toH) begin
            enH = e; ifH.obs_d = d; ifH.obs_set_n = sn; ifH.obs_reset_n = rn;
            ifH.obs_q = q; ifH.obs_qbar = qb;
        end else begin
            enA = e; ifA.obs_d = d; ifA.obs_set_n = sn; ifA.obs_reset_n = rn;
            ifA.obs_q = q; ifA.obs_qbar = qb;
        end
        @(posedge clk);
        #1;
    endtask

    // d and q per edge after reset release; edge 5 carries a wrong q.
    bit pdV  [8]  = '{0, 1, 0, 1, 1, 0, 1, 0};
    bit pqV  [8]  = '{0, 0, 1, 0, 1, 0, 0, 1};
    bit pErr [8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    // Halt scenario: edge 4 carries a wrong q, later edges are wrong too.
    bit hqV  [10] = '{0, 0, 1, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        rstA = 1'b1; rstH = 1'b1; enA = 1'b1; enH = 1'b1;
        ifH.obs_d = 1'b0; ifH.obs_set_n = 1'b1; ifH.obs_reset_n = 1'b1;
        ifH.obs_q = 1'b0; ifH.obs_qbar = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("[TB] reset state");
        checkOutput("rst err", errA, 0);
        checkOutput("rst compl_err", complA, 0);
        checkOutput("rst illegal", illA, 0);
        checkOutput("rst err_count", cntA, 0);
        checkOutput("rst first_valid", fvA, 0);
        checkOutput("rst first_cycle", fcA, 0);
        checkOutput("rst armed", armA, 0);
        checkOutput("rstH armed", armH, 0);

        $display("[TB] clean run then a single data error at edge 5");
        rstA = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, pdV[i], 1'b1, 1'b1, pqV[i], !pqV[i]);
            checkOutput($sformatf("p1 err e%0d", i), errA, pErr[i]);
            checkOutput($sformatf("p1 armed e%0d", i), armA, 1);
            if (i == 5) begin
                checkOutput("p1 compl_err e5", complA, 0);
                checkOutput("p1 err_count e5", cntA, 1);
                checkOutput("p1 first_valid e5", fvA, 1);
                checkOutput("p1 first_cycle e5", fcA, 5);
            end
        end
        checkOutput("p1 err_count end", cntA, 1);

        $display("[TB] asynchronous reset_n");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("async e8 err", errA, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("async e9 err", errA, 0);
        checkOutput("sync e9 err", errS, 1);
        checkOutput("sync e9 err_count", cntS, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("async e10 err", errA, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("async e11 err", errA, 1);
        checkOutput("async e11 compl_err", complA, 0);
        checkOutput("async e11 err_count", cntA, 2);
        checkOutput("async e11 first_cycle", fcA, 5);
        checkOutput("sync e11 err", errS, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("async e12 err", errA, 0);

        $display("[TB] illegal controls");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("ill e13 illegal", illA, 1);
        checkOutput("ill e13 armed", armA, 0);
        checkOutput("ill e13 err", errA, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("ill e14 illegal", illA, 1);
        checkOutput("ill e14 armed", armA, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("ill e15 illegal", illA, 0);
        checkOutput("ill e15 armed", armA, 1);
        checkOutput("ill e15 err", errA, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("ill e16 err", errA, 0);

        $display("[TB] qbar tied to q, counter saturation");
        complPulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, (i % 2 == 0), 1'b1, 1'b1, (i % 2 != 0), (i % 2 != 0));
            if (complA) complPulses++;
            checkOutput($sformatf("compl e%0d compl_err", 17 + i), complA, 1);
            checkOutput($sformatf("compl e%0d err", 17 + i), errA, 1);
            checkOutput($sformatf("compl e%0d err_count", 17 + i), cntA, 3);
        end
        checkOutput("compl pulse total", complPulses, 6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("e23 compl_err", complA, 0);
        checkOutput("e23 err_count", cntA, 3);

        $display("[TB] enable low");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("en0 e24 err", errA, 0);
        checkOutput("en0 e24 armed", armA, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("en1 e25 err", errA, 0);

        $display("[TB] reset mid-operation");
        rstA = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("mid rst err_count", cntA, 0);
        checkOutput("mid rst first_valid", fvA, 0);
        checkOutput("mid rst first_cycle", fcA, 0);
        checkOutput("mid rst armed", armA, 0);

        $display("[TB] stop on first failure");
        rstH = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, (i % 2 != 0), 1'b1, 1'b1, hqV[i], !hqV[i]);
            checkOutput($sformatf("halt h%0d err", i), errH, (i == 4));
            checkOutput($sformatf("halt h%0d err_count", i), cntH, (i >= 4));
            checkOutput($sformatf("halt h%0d armed", i), armH, (i < 4));
        end
        checkOutput("halt first_valid", fvH, 1);
        checkOutput("halt first_cycle", fcH, 4);
        rstH = 1'b1;
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("halt rst err", errH, 0);
        checkOutput("halt rst compl_err", complH, 0);
        checkOutput("halt rst illegal", illH, 0);
        checkOutput("halt rst err_count", cntH, 0);
        checkOutput("halt rst first_valid", fvH, 0);
        checkOutput("halt rst first_cycle", fcH, 0);
        checkOutput("halt rst armed", armH, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/dflop_monitor.md
Name: dflop_monitor

Overview:
- Synthesizable response checker: the observing end of the D flip-flop stimulus interface.
- Samples the flop's stimulus (d, set_n, reset_n) and its outputs (q, qbar) every clock.
- Runs a cycle-accurate golden flop model, flags mismatches, counts errors and timestamps the first failure.
- Sits beside any dflop instance in bench or on-chip self-test; makes stimulus sequences self-checking.

Parameters:
- ASYNC_CTRL, 1: 1 = set_n/reset_n act on q immediately (asynchronous); 0 = they act only at the clock edge.
- CNT_W, 8: width of the error counter; saturates.
- CYC_W, 16: width of the cycle stamp counter; wraps.
- STOP_ON_FAIL, 0: 1 = stop checking after the first error.

Ports:
- clk  input  1  monitor clock; same clock as the monitored flop; rising edge.
- reset  input  1  synchronous, active-high monitor reset.
- en  input  1  checking enable; when 0 the model still tracks but no compare is made.
- obs_d  input  1  D input driven to the flop.
- obs_set_n  input  1  active-low set driven to the flop.
- obs_reset_n  input  1  active-low reset driven to the flop.
- obs_q  input  1  flop q output.
- obs_qbar  input  1  flop qbar output.
- err  output  1  one-cycle pulse on any detected error.
- compl_err  output  1  one-cycle pulse: obs_q == obs_qbar while controls are legal.
- illegal_ctrl  output  1  one-cycle pulse: obs_set_n = 0 and obs_reset_n = 0 together.
- err_count  output  CNT_W  total errors; saturating.
- first_err_valid  output  1  sticky; a first error has been recorded.
- first_err_cycle  output  CYC_W  cycle stamp of the first error.
- armed  output  1  model holds a known value; checking is active.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: err, compl_err, illegal_ctrl, first_err_valid, armed = 0; err_count = 0; first_err_cycle = 0; cycle counter = 0; state = UNINIT.
- Cycle counter: increments every non-reset edge; wraps at 2^CYC_W.
- Golden model q_exp is updated at every edge:
  - reset_n = 0 -> q_exp = 0
  - else set_n = 0 -> q_exp = 1
  - else q_exp = d
- Expected value at edge k+1, exp:
  - ASYNC_CTRL = 1: current obs_reset_n = 0 -> 0; else current obs_set_n = 0 -> 1; else q_exp registered at edge k.
  - ASYNC_CTRL = 0: q_exp registered at edge k.
- Checks at an edge, made only when armed and en = 1:
  - data mismatch: obs_q != exp
  - complement error: obs_q == obs_qbar
  - either one asserts err the next cycle (registered); compl_err pulses for the complement case.
- Illegal controls (both set_n and reset_n low, current sample):
  - illegal_ctrl pulses.
  - Compare is skipped that cycle.
  - q_exp is marked unknown and state returns to UNINIT.
- States:
  - UNINIT: not armed. -> ARMED on the first edge where a legal control is active (model forced) or obs_set_n = obs_reset_n = 1 (model clocked from d). No compare on the transition edge.
  - ARMED: compare each enabled cycle. On error with STOP_ON_FAIL = 1 -> HALT. Illegal controls -> UNINIT.
  - HALT: err and compl_err held 0; counters frozen; leaves only on reset.
- First error: first_err_cycle = cycle count at the failing edge, and first_err_valid is set. Later errors do not overwrite it.
- err_count: +1 per erroring cycle, counting a data and a complement error in the same cycle as one. Holds at 2^CNT_W - 1.
- en = 0: no compare and no counting; q_exp still tracks; state unchanged.
- reset asserted mid-operation: all outputs return to reset values next edge; the model must re-arm.
- Latency: from the flop edge to the err pulse is one clk.

Decomposition:
- Shared package dflop_pkg holds:
  - monitor state encoding: UNINIT, ARMED, HALT
  - model priority constants: reset over set over d
  - default widths
- One natural sub-module, dflop_model: the golden flop. Inputs clk, reset, d, set_n, reset_n; outputs q_exp and exp, taking ASYNC_CTRL. It is reusable by future latch and flop checkers.

Test Plan:
- Controls held at 1; d = 0, 1, 0, 1 on successive edges; obs_q follows correctly one edge later -> armed = 1 after the first edge, err never asserts, err_count = 0.
- Same sequence with obs_q forced to 0 at cycle 5 -> err pulses once at cycle 6, first_err_cycle = 5, first_err_valid = 1, err_count = 1.
- ASYNC_CTRL = 1; obs_reset_n pulled low mid-cycle with d = 1 and obs_q dropping to 0 -> no error. Repeat with obs_q staying 1 -> err.
- Both set_n and reset_n = 0 for 2 cycles, then both 1 -> illegal_ctrl pulses twice, armed drops to 0, then re-arms with no false err.
- CNT_W = 2, obs_qbar tied to obs_q for 6 armed cycles -> compl_err pulses 6 times, err_count saturates at 3.
- STOP_ON_FAIL = 1, error at cycle 4, then reset at cycle 10 -> err pulses once and counters freeze, then all outputs are 0 after cycle 11.
